// File: rtl/solitaire_pkg.sv
// Shared definitions for the peg solitaire front-end and board stage.
// Contents:
//   BOARD_WIDTH, MIN_VAL, MAX_VAL : geometry of the 7x7 cross-shaped board
//   dir_t                         : move direction encoding (LEFT/RIGHT/UP/DOWN)
//   entry_state_t                 : move-entry FSM states
//   space_exists(x, y)            : 1 when (x, y) is a hole on the board
package solitaire_pkg;

  localparam int BOARD_WIDTH = 7;
  localparam int MIN_VAL     = 2;
  localparam int MAX_VAL     = 4;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic {
    ST_CURSOR = 1'b0,
    ST_DIR    = 1'b1
  } entry_state_t;

  // Arguments are one bit wider than a board coordinate so that a probe
  // one step off the board (including 0 - 1, which becomes 15) can be
  // classified without any wrap back onto a real column or row.
  function automatic logic space_exists(input logic [3:0] x, input logic [3:0] y);
    logic in_range;
    logic in_col;
    logic in_row;
    in_range = (x < 4'(BOARD_WIDTH)) && (y < 4'(BOARD_WIDTH));
    in_col   = (x >= 4'(MIN_VAL)) && (x <= 4'(MAX_VAL));
    in_row   = (y >= 4'(MIN_VAL)) && (y <= 4'(MAX_VAL));
    return in_range && (in_col || in_row);
  endfunction

endpackage

// File: rtl/solitaire_move_entry_btn_debounce.sv
// btn_debounce: conditions one raw asynchronous push-button.
//   2-flop synchroniser -> stability counter -> registered rising-edge pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw button level, active-high
//   press      : one-cycle pulse on each accepted 0->1 transition
// Parameter:
//   DEBOUNCE_CYCLES : cycles the synchronised level must differ from the
//                     accepted state before it is taken (min 2)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_lvl;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_lvl  <= sync_meta;
    end
  end

  // Any sample agreeing with the accepted state restarts the count, so a
  // bouncing contact never accumulates towards a flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_lvl == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/solitaire_move_entry.sv
// solitaire_move_entry: turns five push-buttons into a board cursor and
// one-cycle move commands for the peg solitaire board stage.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   btn_left/right/up/down/select : raw buttons, active-high
//   cursor_x, cursor_y    : cursor position for display
//   dir_mode              : 1 while a peg is selected and a direction awaited
//   move_valid            : one-cycle strobe qualifying piece_x/y, direction
//   piece_x, piece_y      : source peg of the last move (held)
//   direction             : direction of the last move (held)
//   move_count            : moves issued since reset, saturating at 63
// Move legality is not checked here; the board stage owns that.
module solitaire_move_entry
  import solitaire_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CURSOR_RST_X    = 3,
  parameter int CURSOR_RST_Y    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       dir_mode,
  output logic       move_valid,
  output logic [2:0] piece_x,
  output logic [2:0] piece_y,
  output logic [1:0] direction,
  output logic [5:0] move_count
);

  // Bit order: 0 LEFT, 1 RIGHT, 2 UP, 3 DOWN, 4 SELECT.
  logic [4:0] btn_raw;
  logic [4:0] press;

  assign btn_raw = {btn_select, btn_down, btn_up, btn_right, btn_left};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  entry_state_t state;
  entry_state_t state_next;
  logic [2:0]   cursor_x_next;
  logic [2:0]   cursor_y_next;
  logic         issue;
  logic         sel_ev;
  logic         dir_ev;
  dir_t         ev_dir;
  logic [3:0]   tgt_x;
  logic [3:0]   tgt_y;

  // Event arbitration: SELECT beats every direction, and among directions
  // the lowest bit index wins. Anything that loses is simply dropped.
  always_comb begin
    sel_ev = press[4];
    dir_ev = |press[3:0];
    ev_dir = LEFT;
    if (press[0])      ev_dir = LEFT;
    else if (press[1]) ev_dir = RIGHT;
    else if (press[2]) ev_dir = UP;
    else if (press[3]) ev_dir = DOWN;
  end

  // One-step target in 4-bit arithmetic; stepping left/up from 0 yields 15,
  // which space_exists rejects, so the cursor never wraps.
  always_comb begin
    tgt_x = {1'b0, cursor_x};
    tgt_y = {1'b0, cursor_y};
    case (ev_dir)
      LEFT:    tgt_x = {1'b0, cursor_x} - 4'd1;
      RIGHT:   tgt_x = {1'b0, cursor_x} + 4'd1;
      UP:      tgt_y = {1'b0, cursor_y} - 4'd1;
      default: tgt_y = {1'b0, cursor_y} + 4'd1;
    endcase
  end

  always_comb begin
    state_next    = state;
    cursor_x_next = cursor_x;
    cursor_y_next = cursor_y;
    issue         = 1'b0;
    case (state)
      ST_CURSOR: begin
        if (sel_ev) begin
          state_next = ST_DIR;
        end else if (dir_ev && space_exists(tgt_x, tgt_y)) begin
          cursor_x_next = tgt_x[2:0];
          cursor_y_next = tgt_y[2:0];
        end
      end
      default: begin
        if (sel_ev) begin
          state_next = ST_CURSOR;
        end else if (dir_ev) begin
          issue      = 1'b1;
          state_next = ST_CURSOR;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CURSOR;
      cursor_x <= 3'(CURSOR_RST_X);
      cursor_y <= 3'(CURSOR_RST_Y);
    end else begin
      state    <= state_next;
      cursor_x <= cursor_x_next;
      cursor_y <= cursor_y_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_valid <= 1'b0;
      piece_x    <= 3'd0;
      piece_y    <= 3'd0;
      direction  <= 2'b00;
      move_count <= 6'd0;
    end else begin
      move_valid <= issue;
      if (issue) begin
        piece_x   <= cursor_x;
        piece_y   <= cursor_y;
        direction <= ev_dir;
        if (move_count != 6'd63) begin
          move_count <= move_count + 6'd1;
        end
      end
    end
  end

  assign dir_mode = (state == ST_DIR);

endmodule

// File: tb/tb_solitaire_move_entry.sv
// Testbench for solitaire_move_entry with DEBOUNCE_CYCLES = 4.
// A reference model of the cursor/selection rules predicts the outcome of
// each button press; expected move commands go into a queue that a
// separate monitor drains whenever move_valid is seen.
module tb_solitaire_move_entry;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic       dir_mode;
  logic       move_valid;
  logic [2:0] piece_x;
  logic [2:0] piece_y;
  logic [1:0] direction;
  logic [5:0] move_count;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_S = 5'b10000;

  solitaire_move_entry #(
    .DEBOUNCE_CYCLES(4),
    .CURSOR_RST_X   (3),
    .CURSOR_RST_Y   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_left  (btn[0]),
    .btn_right (btn[1]),
    .btn_up    (btn[2]),
    .btn_down  (btn[3]),
    .btn_select(btn[4]),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .dir_mode  (dir_mode),
    .move_valid(move_valid),
    .piece_x   (piece_x),
    .piece_y   (piece_y),
    .direction (direction),
    .move_count(move_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int px;
    int py;
    int dir;
    int cnt;
  } move_t;

  move_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state
  int m_x;
  int m_y;
  int m_count;
  bit m_dir;

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit on_board(input int x, input int y);
    if (x < 0 || x > 6 || y < 0 || y > 6) return 1'b0;
    // The four 2x2 corner blocks are missing from the cross.
    return !((x < 2 || x > 4) && (y < 2 || y > 4));
  endfunction

  task automatic model_reset();
    m_x     = 3;
    m_y     = 3;
    m_count = 0;
    m_dir   = 1'b0;
  endtask

  // Apply one press (possibly several buttons at once) to the model.
  task automatic model_press(input logic [4:0] mask);
    int b;
    int nx;
    int ny;
    move_t mv;
    if (mask[4]) begin
      m_dir = !m_dir;
    end else if (mask[3:0] != 4'b0) begin
      b = 3;
      for (int i = 3; i >= 0; i--) if (mask[i]) b = i;
      if (m_dir) begin
        m_count = (m_count < 63) ? m_count + 1 : 63;
        mv = '{m_x, m_y, b, m_count};
        exp_q.push_back(mv);
        m_dir = 1'b0;
      end else begin
        nx = m_x;
        ny = m_y;
        case (b)
          0: nx = m_x - 1;
          1: nx = m_x + 1;
          2: ny = m_y - 1;
          default: ny = m_y + 1;
        endcase
        if (on_board(nx, ny)) begin
          m_x = nx;
          m_y = ny;
        end
      end
    end
  endtask

  // Clean press: hold the buttons, release, then let the release settle.
  task automatic apply_stimulus(input logic [4:0] mask, input int hold);
    model_press(mask);
    @(negedge clk);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = 5'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] mask);
    apply_stimulus(mask, 8);
  endtask

  task automatic check_state(input string tag);
    check_output({tag, ".cursor_x"}, int'(cursor_x), m_x);
    check_output({tag, ".cursor_y"}, int'(cursor_y), m_y);
    check_output({tag, ".dir_mode"}, int'(dir_mode), int'(m_dir));
  endtask

  task automatic do_reset();
    check_output("pending_before_reset", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    btn   = 5'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".cursor_x"}, int'(cursor_x), 3);
    check_output({tag, ".cursor_y"}, int'(cursor_y), 3);
    check_output({tag, ".dir_mode"}, int'(dir_mode), 0);
    check_output({tag, ".move_valid"}, int'(move_valid), 0);
    check_output({tag, ".piece_x"}, int'(piece_x), 0);
    check_output({tag, ".piece_y"}, int'(piece_y), 0);
    check_output({tag, ".direction"}, int'(direction), 0);
    check_output({tag, ".move_count"}, int'(move_count), 0);
  endtask

  // Monitor: every strobe must match the oldest expected move, and a strobe
  // may never last two consecutive cycles.
  initial begin
    bit prev_valid;
    move_t mv;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && move_valid) begin
        check_output("strobe_single_cycle", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          check_output("unexpected_move", 1, 0);
        end else begin
          mv = exp_q.pop_front();
          check_output("move.piece_x", int'(piece_x), mv.px);
          check_output("move.piece_y", int'(piece_y), mv.py);
          check_output("move.direction", int'(direction), mv.dir);
          check_output("move.move_count", int'(move_count), mv.cnt);
        end
      end
      prev_valid = rst_n && move_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    btn   = 5'b0;
    model_reset();
    do_reset();
    #1;
    check_reset_values("reset");

    // Scenario 1: latency and no auto-repeat while held.
    $display("[TB] scenario 1: latency");
    model_press(B_R);
    @(negedge clk);
    btn = B_R;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (k == 7) check_output("lat.before_x", int'(cursor_x), 3);
      if (k == 8) check_output("lat.step_x", int'(cursor_x), 4);
      if (k == 8) check_output("lat.no_strobe", int'(move_valid), 0);
    end
    check_output("lat.held_x", int'(cursor_x), 4);
    @(negedge clk);
    btn = 5'b0;
    repeat (10) @(negedge clk);
    check_state("lat");

    // Scenario 2: edges of the cross.
    $display("[TB] scenario 2: boundaries");
    do_reset();
    press(B_U);
    press(B_U);
    press(B_R);
    press(B_R);
    check_output("edge.right_x", int'(cursor_x), 4);
    check_output("edge.right_y", int'(cursor_y), 1);
    do_reset();
    press(B_U);
    for (int i = 0; i < 4; i++) press(B_L);
    check_output("edge.left_x", int'(cursor_x), 0);
    check_output("edge.left_y", int'(cursor_y), 2);

    // Scenario 3: bouncing contact is ignored.
    $display("[TB] scenario 3: bounce");
    for (int i = 0; i < 6; i++) begin
      btn = (i % 2 == 0) ? B_R : 5'b0;
      repeat (2) @(negedge clk);
    end
    btn = 5'b0;
    repeat (12) @(negedge clk);
    check_output("bounce.x", int'(cursor_x), 0);
    check_output("bounce.y", int'(cursor_y), 2);

    // Scenario 4: select then direction issues one move.
    $display("[TB] scenario 4: move");
    do_reset();
    press(B_U);
    press(B_U);
    press(B_S);
    check_output("move4.dir_mode_on", int'(dir_mode), 1);
    press(B_D);
    check_output("move4.dir_mode_off", int'(dir_mode), 0);
    check_output("move4.cursor_x", int'(cursor_x), 3);
    check_output("move4.cursor_y", int'(cursor_y), 1);
    check_output("move4.count", int'(move_count), 1);
    check_output("move4.piece_x", int'(piece_x), 3);
    check_output("move4.direction", int'(direction), 3);

    // Scenario 5: cancel, and SELECT wins simultaneous events.
    $display("[TB] scenario 5: cancel and priority");
    press(B_S);
    press(B_S);
    check_state("cancel");
    apply_stimulus(B_S | B_L, 8);
    check_state("prio_cursor");
    apply_stimulus(B_S | B_L, 8);
    check_state("prio_dir");
    apply_stimulus(B_R | B_D, 8);
    check_state("prio_dirs");

    // Randomised presses against the model.
    $display("[TB] random presses");
    for (int i = 0; i < 60; i++) begin
      logic [4:0] m;
      m = 5'b00001 << $urandom_range(0, 4);
      apply_stimulus(m, $urandom_range(7, 12));
      check_state("rand");
    end
    if (m_dir) press(B_S);

    // Scenario 6: saturation, then reset in the middle of a direction.
    $display("[TB] scenario 6: saturation and abort");
    do_reset();
    for (int i = 0; i < 65; i++) begin
      logic [4:0] d;
      press(B_S);
      d = 5'b00001 << $urandom_range(0, 3);
      press(d);
    end
    check_output("sat.count", int'(move_count), 63);
    check_output("sat.pending", exp_q.size(), 0);
    press(B_S);
    check_output("abort.dir_mode", int'(dir_mode), 1);
    @(negedge clk);
    btn = B_D;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort_in_reset");
    @(negedge clk);
    btn = 5'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
    check_reset_values("abort_after");

    check_output("final_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
